mem_uart_backend: RTL and testbench

MEM_UART_BACKEND -- requirements
Module: mem_uart_backend

---
 rtl/mem_uart_backend.sv | 190 +++++++++++++++++++
 tb/tb_mem_uart_backend.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_uart_backend.sv
// Memory/UART backend behind an MMU: byte-serial RAM accesses plus a
// memory-mapped UART with 4-entry TX and RX FIFOs, four-phase level handshake.
module mem_uart_backend #(
    parameter int                  M_ADDR_W  = 32,
    parameter int                  DATA_W    = 32,
    parameter int                  RAM_AW    = 16,
    parameter logic [M_ADDR_W-1:0] UART_ADDR = 32'h0001_0000,
    parameter logic [M_ADDR_W-1:0] UART_STAT = 32'h0001_0004
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                re,
    input  logic [M_ADDR_W-1:0] raddr,
    input  logic [1:0]          rlen,
    output logic [DATA_W-1:0]   rdata,
    output logic                rack,
    input  logic                we,
    input  logic [M_ADDR_W-1:0] waddr,
    input  logic [1:0]          wlen,
    input  logic [DATA_W-1:0]   wdata,
    output logic                wack,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid
);

    typedef enum logic [2:0] {IDLE, RD, WR, TXW, ACK_R, ACK_W} state_t;
    typedef enum logic [1:0] {MODE_RAM, MODE_UDATA, MODE_USTAT} mode_t;

    state_t              r_state, w_next;
    mode_t               r_mode;
    logic [RAM_AW-1:0]   r_addr;
    logic [1:0]          r_len;
    logic [1:0]          r_cnt;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rack;
    logic                r_wack;

    logic [7:0]          r_ram [0:(1<<RAM_AW)-1];

    logic [7:0]          r_tx_mem [0:3];
    logic [1:0]          r_tx_wp, r_tx_rp;
    logic [2:0]          r_tx_cnt;
    logic [7:0]          r_rx_mem [0:3];
    logic [1:0]          r_rx_wp, r_rx_rp;
    logic [2:0]          r_rx_cnt;
    logic                r_rx_ovf;

    logic [RAM_AW-1:0]   w_ram_idx;
    logic                w_last;
    logic                w_ram_we;
    logic                w_tx_push, w_tx_pop, w_tx_space, w_tx_notfull;
    logic                w_rx_push, w_rx_pop, w_rx_drop, w_rx_nonempty;
    logic                w_ovf_clr;
    logic [DATA_W-1:0]   w_stat;
    mode_t               w_wmode, w_rmode;

    assign w_ram_idx     = r_addr + RAM_AW'(r_cnt);
    assign w_last        = (r_cnt == r_len);
    assign w_tx_notfull  = (r_tx_cnt != 3'd4);
    assign w_rx_nonempty = (r_rx_cnt != 3'd0);
    assign tx_valid      = (r_tx_cnt != 3'd0);
    assign tx_data       = tx_valid ? r_tx_mem[r_tx_rp] : '0;
    assign w_tx_pop      = tx_valid & tx_ready;
    // A full TX FIFO still takes the push when the head leaves this cycle.
    assign w_tx_space    = w_tx_notfull | w_tx_pop;
    assign w_rx_push     = rx_valid & ((r_rx_cnt != 3'd4) | w_rx_pop);
    assign w_rx_drop     = rx_valid & ~w_rx_push;

    assign rdata = r_rdata;
    assign rack  = r_rack;
    assign wack  = r_wack;

    always_comb begin
        w_wmode = MODE_RAM;
        if (waddr == UART_STAT)      w_wmode = MODE_USTAT;
        else if (waddr == UART_ADDR) w_wmode = MODE_UDATA;
        w_rmode = MODE_RAM;
        if (raddr == UART_STAT)      w_rmode = MODE_USTAT;
        else if (raddr == UART_ADDR) w_rmode = MODE_UDATA;
        w_stat      = '0;
        w_stat[2:0] = {r_rx_ovf, w_rx_nonempty, w_tx_notfull};
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_ram_we  = 1'b0;
        w_tx_push = 1'b0;
        w_rx_pop  = 1'b0;
        w_ovf_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (we)      w_next = (waddr == UART_ADDR) ? TXW : WR;
                else if (re) w_next = RD;
            end
            RD: begin
                w_rx_pop = (r_mode == MODE_UDATA) & w_rx_nonempty;
                if (r_mode != MODE_RAM || w_last) w_next = ACK_R;
            end
            WR: begin
                w_ram_we  = (r_mode == MODE_RAM);
                w_ovf_clr = (r_mode == MODE_USTAT);
                if (r_mode != MODE_RAM || w_last) w_next = ACK_W;
            end
            TXW: begin
                w_tx_push = w_tx_space;
                if (w_tx_space) w_next = ACK_W;
            end
            ACK_R:   if (!re) w_next = IDLE;
            ACK_W:   if (!we) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= MODE_RAM;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_rack   <= 1'b0;
            r_wack   <= 1'b0;
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
            r_rx_ovf <= 1'b0;
        end else begin
            // Acks are registered, so they drop on the edge that sees the request low.
            r_rack <= (r_state == ACK_R) & re;
            r_wack <= (r_state == ACK_W) & we;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (we) begin
                        r_addr  <= waddr[RAM_AW-1:0];
                        r_len   <= wlen;
                        r_wdata <= wdata;
                        r_mode  <= w_wmode;
                    end else if (re) begin
                        r_addr  <= raddr[RAM_AW-1:0];
                        r_len   <= rlen;
                        r_rdata <= '0;
                        r_mode  <= w_rmode;
                    end
                end
                RD: begin
                    r_cnt <= r_cnt + 2'd1;
                    case (r_mode)
                        MODE_RAM:   r_rdata[{r_cnt, 3'b000} +: 8] <= r_ram[w_ram_idx];
                        MODE_UDATA: r_rdata[7:0] <= w_rx_nonempty ? r_rx_mem[r_rx_rp] : 8'h00;
                        default:    r_rdata <= w_stat;
                    endcase
                end
                WR:      r_cnt <= r_cnt + 2'd1;
                default: ;
            endcase

            if (w_tx_push) r_tx_wp <= r_tx_wp + 2'd1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 2'd1;
            r_tx_cnt <= r_tx_cnt + 3'(w_tx_push) - 3'(w_tx_pop);

            if (w_rx_push) r_rx_wp <= r_rx_wp + 2'd1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 2'd1;
            r_rx_cnt <= r_rx_cnt + 3'(w_rx_push) - 3'(w_rx_pop);

            if (w_rx_drop)      r_rx_ovf <= 1'b1;
            else if (w_ovf_clr) r_rx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we && !rst) r_ram[w_ram_idx] <= r_wdata[{r_cnt, 3'b000} +: 8];
        if (w_tx_push)        r_tx_mem[r_tx_wp] <= r_wdata[7:0];
        if (w_rx_push)        r_rx_mem[r_rx_wp] <= rx_data;
    end

endmodule

// File: tb/tb_mem_uart_backend.sv
// Scoreboard bench for mem_uart_backend: reads push expected data that is
// popped on rack; a TX monitor pops expected bytes as they leave the FIFO.
module tb_mem_uart_backend;

    localparam logic [31:0] UA = 32'h0001_0000;
    localparam logic [31:0] US = 32'h0001_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic        re, we;
    logic [31:0] raddr, waddr, wdata;
    logic [1:0]  rlen, wlen;
    logic [31:0] rdata;
    logic        rack, wack;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd_q [$];
    logic [7:0]  tx_q [$];
    logic [7:0]  mdl  [int];

    always #5 clk = ~clk;

    mem_uart_backend #(
        .M_ADDR_W (32),
        .DATA_W   (32),
        .RAM_AW   (16),
        .UART_ADDR(UA),
        .UART_STAT(US)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .re      (re),
        .raddr   (raddr),
        .rlen    (rlen),
        .rdata   (rdata),
        .rack    (rack),
        .we      (we),
        .waddr   (waddr),
        .wlen    (wlen),
        .wdata   (wdata),
        .wack    (wack),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic wait_ack(input bit w, input int max, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (w ? wack : rack) begin
                got = 1'b1;
                cyc = i;
                break;
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] l);
        logic [31:0] v = '0;
        for (int k = 0; k <= int'(l); k++)
            v[8*k +: 8] = mdl[int'((a + 32'(k)) & 32'h0000_FFFF)];
        return v;
    endfunction

    task automatic do_read(input logic [31:0] a, input logic [1:0] l, input logic [31:0] exp);
        bit          got;
        int          cyc;
        int          lat;
        logic [31:0] e;
        lat = (a == UA || a == US) ? 3 : int'(l) + 3;
        rd_q.push_back(exp);
        raddr = a;
        rlen  = l;
        re    = 1'b1;
        wait_ack(1'b0, 20, got, cyc);
        check_eq("rack_seen", 32'(got), 32'd1);
        e = rd_q.pop_front();
        if (got) begin
            check_eq("rdata", rdata, e);
            check_eq("rd_latency", cyc, lat);
        end
        re = 1'b0;
        @(negedge clk);
        check_eq("rack_drop", 32'(rack), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d);
        bit got;
        int cyc;
        int lat;
        lat = (a == UA || a == US) ? 3 : int'(l) + 3;
        if (a == UA) tx_q.push_back(d[7:0]);
        else if (a != US)
            for (int k = 0; k <= int'(l); k++)
                mdl[int'((a + 32'(k)) & 32'h0000_FFFF)] = d[8*k +: 8];
        waddr = a;
        wlen  = l;
        wdata = d;
        we    = 1'b1;
        wait_ack(1'b1, 20, got, cyc);
        check_eq("wack_seen", 32'(got), 32'd1);
        if (got) check_eq("wr_latency", cyc, lat);
        we = 1'b0;
        @(negedge clk);
        check_eq("wack_drop", 32'(wack), 32'd0);
    endtask

    // TX monitor samples mid-low-phase, after negedge-driven inputs settle.
    always begin
        @(negedge clk);
        #2;
        if (!rst && tx_valid && tx_ready) begin
            if (tx_q.size() > 0) check_eq("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
            else                 check_eq("tx_extra", 32'(tx_valid), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          got;
        int          cyc;
        int          hits;
        logic [31:0] a, d;
        logic [1:0]  l;

        rst = 1'b1; re = 1'b0; we = 1'b0;
        raddr = '0; waddr = '0; wdata = '0; rlen = '0; wlen = '0;
        tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_rack", 32'(rack), 32'd0);
        check_eq("rst_wack", 32'(wack), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        do_read(US, 2'd0, 32'h1);

        // Basic RAM write/read and sub-word read
        do_write(32'h10, 2'd3, 32'hDEAD_BEEF);
        do_read(32'h10, 2'd3, 32'hDEAD_BEEF);
        do_read(32'h11, 2'd0, 32'h0000_00BE);
        do_read(32'h12, 2'd1, 32'h0000_DEAD);

        // Wrap-around at the top of RAM, upper address bits ignored
        do_write(32'hFFFF, 2'd1, 32'h0000_1234);
        do_read(32'hFFFF, 2'd0, 32'h34);
        do_read(32'h0000, 2'd0, 32'h12);
        do_read(32'h0001_FFFF, 2'd1, 32'h1234);

        // Simultaneous re/we: write served first, read sees new data
        mdl[int'(32'h40)] = 8'h0D; mdl[int'(32'h41)] = 8'hF0;
        mdl[int'(32'h42)] = 8'hFE; mdl[int'(32'h43)] = 8'hCA;
        waddr = 32'h40; wlen = 2'd3; wdata = 32'hCAFE_F00D;
        raddr = 32'h40; rlen = 2'd3;
        rd_q.push_back(32'hCAFE_F00D);
        we = 1'b1; re = 1'b1;
        wait_ack(1'b1, 20, got, cyc);
        check_eq("simul_wack", 32'(got), 32'd1);
        check_eq("simul_rack_low", 32'(rack), 32'd0);
        we = 1'b0;
        @(negedge clk);
        check_eq("simul_wack_drop", 32'(wack), 32'd0);
        wait_ack(1'b0, 20, got, cyc);
        check_eq("simul_rack", 32'(got), 32'd1);
        check_eq("simul_rdata", rdata, rd_q.pop_front());
        re = 1'b0;
        @(negedge clk);

        // Random RAM traffic checked against the byte model
        for (int i = 0; i < 6; i++) begin
            a = 32'($urandom_range(32'h0100, 32'h01F0));
            l = 2'($urandom_range(0, 3));
            d = $urandom;
            do_write(a, l, d);
            do_read(a, l, model_read(a, l));
        end

        // TX FIFO fill, stall on fifth, drain in order
        tx_ready = 1'b0;
        for (int b = 1; b <= 4; b++) do_write(UA, 2'd0, 32'(b));
        tx_q.push_back(8'd5);
        waddr = UA; wlen = 2'd0; wdata = 32'd5; we = 1'b1;
        wait_ack(1'b1, 10, got, cyc);
        check_eq("tx_stall", 32'(got), 32'd0);
        tx_ready = 1'b1;
        wait_ack(1'b1, 10, got, cyc);
        check_eq("tx_fifth_wack", 32'(got), 32'd1);
        we = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("tx_drained", tx_q.size(), 32'd0);
        check_eq("tx_idle", 32'(tx_valid), 32'd0);

        // RX FIFO overflow and status, with TX FIFO held full
        tx_ready = 1'b0;
        for (int b = 0; b < 4; b++) do_write(UA, 2'd0, 32'h11 + 32'(b));
        for (int i = 0; i < 5; i++) begin
            rx_data  = 8'hA0 + 8'(i);
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        @(negedge clk);
        do_read(US, 2'd0, 32'h6);
        for (int i = 0; i < 4; i++) do_read(UA, 2'd3, 32'hA0 + 32'(i));
        do_read(UA, 2'd0, 32'h0);
        tx_ready = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("tx_drained2", tx_q.size(), 32'd0);
        do_read(US, 2'd0, 32'h5);
        do_write(US, 2'd0, 32'h0);
        do_read(US, 2'd0, 32'h1);

        // Reset in the middle of a RAM read abandons it
        raddr = 32'h10; rlen = 2'd3; re = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; re = 1'b0;
        check_eq("mid_rst_rdata", rdata, 32'd0);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rack) hits++;
        end
        check_eq("mid_rst_no_rack", hits, 32'd0);
        do_read(32'h10, 2'd3, 32'hDEAD_BEEF);

        // Write held through reset is served afterwards
        rst = 1'b1;
        waddr = 32'h20; wlen = 2'd0; wdata = 32'h5A; we = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("held_wack_in_rst", 32'(wack), 32'd0);
        rst = 1'b0;
        wait_ack(1'b1, 20, got, cyc);
        check_eq("held_wr_served", 32'(got), 32'd1);
        we = 1'b0;
        @(negedge clk);
        do_read(32'h20, 2'd0, 32'h5A);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
